// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned word into the IF/ID latch, honouring stall and redirect.
module inst_fetch_stage #(
  parameter int unsigned      DBITS     = 32,
  parameter logic [DBITS-1:0] INST_SIZE = DBITS'(4),
  parameter logic [DBITS-1:0] START_PC  = DBITS'(32'h40),
  parameter logic [DBITS-1:0] NOP_WORD  = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [DBITS-1:0] pc_out,
  input  logic [DBITS-1:0] inst_word,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [DBITS-1:0] redirect_pc,
  output logic [DBITS-1:0] id_inst,
  output logic [DBITS-1:0] id_pc,
  output logic [DBITS-1:0] id_pc_next,
  output logic             id_valid,
  output logic             misalign_err
);

  logic [DBITS-1:0] pc_reg, pc_next;
  logic [DBITS-1:0] inst_reg, inst_next;
  logic [DBITS-1:0] ipc_reg, ipc_next;
  logic [DBITS-1:0] ipcn_reg, ipcn_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic [DBITS-1:0] pc_plus;

  assign pc_plus = pc_reg + INST_SIZE;

  // Redirect beats stall so a flushed latch never holds a stale live instruction.
  always_comb begin
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    ipc_next   = ipc_reg;
    ipcn_next  = ipcn_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    if (redirect_valid) begin
      pc_next    = {redirect_pc[DBITS-1:2], 2'b00};
      inst_next  = NOP_WORD;
      valid_next = 1'b0;
      err_next   = err_reg | (|redirect_pc[1:0]);
    end else if (!stall) begin
      pc_next    = pc_plus;
      inst_next  = inst_word;
      ipc_next   = pc_reg;
      ipcn_next  = pc_plus;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= START_PC;
      inst_reg  <= NOP_WORD;
      ipc_reg   <= '0;
      ipcn_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      ipc_reg   <= ipc_next;
      ipcn_reg  <= ipcn_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  assign pc_out       = pc_reg;
  assign id_inst      = inst_reg;
  assign id_pc        = ipc_reg;
  assign id_pc_next   = ipcn_reg;
  assign id_valid     = valid_reg;
  assign misalign_err = err_reg;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed scenarios plus randomized
// stall/redirect traffic checked against a behavioural fetch model.
module tb_inst_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] inst_word;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic        id_valid;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  // Expected architectural state of the stage.
  logic [31:0] m_pc, m_inst, m_ipc, m_ipcn;
  logic        m_valid, m_err;

  inst_fetch_stage dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .inst_word(inst_word),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_next(id_pc_next),
    .id_valid(id_valid), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  mem_word = 32'h2f000000;
      32'h44:  mem_word = 32'h3b000700;
      32'h48:  mem_word = 32'hc0fffd00;
      default: mem_word = (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endcase
  endfunction

  always_comb inst_word = mem_word(pc_out);

  task automatic model_reset();
    m_pc = 32'h40; m_inst = 32'h0; m_ipc = 32'h0; m_ipcn = 32'h0;
    m_valid = 1'b0; m_err = 1'b0;
  endtask

  // One clock edge with the given controls; the model follows the fetch rules.
  task automatic apply_edge(input logic s, input logic rv, input logic [31:0] rpc);
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    if (rv) begin
      m_pc = rpc - (rpc % 4);
      m_inst = 32'h0;
      m_valid = 1'b0;
      if (rpc % 4 != 0) m_err = 1'b1;
    end else if (!s) begin
      m_inst = mem_word(m_pc);
      m_ipc = m_pc;
      m_ipcn = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    #1;
    stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL reset_pc_out got=%h exp=%h", pc_out, 32'h40); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got=%h exp=0", id_inst); end
    checks++; if (id_pc !== 32'h0 || id_pc_next !== 32'h0) begin errors++; $display("FAIL reset_id_pc got=%h/%h exp=0/0", id_pc, id_pc_next); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    @(negedge clk);
    reset = 1'b0;
    $display("reset: pc_out=%h id_valid=%b", pc_out, id_valid);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_inst [2];
    exp_inst[0] = 32'h2f000000; exp_inst[1] = 32'h3b000700;
    for (int i = 0; i < 2; i++) begin
      apply_edge(1'b0, 1'b0, 32'h0);
      checks++; if (id_inst !== exp_inst[i]) begin errors++; $display("FAIL seq_inst%0d got=%h exp=%h", i, id_inst, exp_inst[i]); end
      checks++; if (id_pc !== 32'h40 + 32'(4*i) || id_pc_next !== 32'h44 + 32'(4*i)) begin errors++; $display("FAIL seq_pc%0d got=%h/%h exp=%h/%h", i, id_pc, id_pc_next, 32'h40 + 32'(4*i), 32'h44 + 32'(4*i)); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got=%b exp=1", i, id_valid); end
      $display("seq: id_pc=%h id_inst=%h", id_pc, id_inst);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      apply_edge(1'b1, 1'b0, 32'h0);
      checks++; if (id_inst !== 32'h3b000700 || pc_out !== 32'h48) begin errors++; $display("FAIL stall_hold%0d got=%h/%h exp=3b000700/00000048", i, id_inst, pc_out); end
      $display("stall: pc_out=%h id_inst=%h", pc_out, id_inst);
    end
    apply_edge(1'b0, 1'b0, 32'h0);
    checks++; if (id_inst !== 32'hc0fffd00 || id_pc !== 32'h48 || id_pc_next !== 32'h4c) begin errors++; $display("FAIL stall_release got=%h/%h/%h exp=c0fffd00/00000048/0000004c", id_inst, id_pc, id_pc_next); end
    $display("stall release: id_pc=%h id_inst=%h", id_pc, id_inst);
  endtask

  task automatic test_redirect();
    apply_edge(1'b0, 1'b1, 32'h44);
    checks++; if (id_valid !== 1'b0 || pc_out !== 32'h44) begin errors++; $display("FAIL redir_bubble got=%b/%h exp=0/00000044", id_valid, pc_out); end
    checks++; if (id_pc !== 32'h48) begin errors++; $display("FAIL redir_idpc_hold got=%h exp=00000048", id_pc); end
    apply_edge(1'b0, 1'b0, 32'h0);
    checks++; if (id_inst !== 32'h3b000700 || id_valid !== 1'b1) begin errors++; $display("FAIL redir_target got=%h/%b exp=3b000700/1", id_inst, id_valid); end
    $display("redirect: id_pc=%h id_inst=%h", id_pc, id_inst);
    apply_edge(1'b1, 1'b1, 32'h40);
    checks++; if (id_valid !== 1'b0 || pc_out !== 32'h40) begin errors++; $display("FAIL redir_stall got=%b/%h exp=0/00000040", id_valid, pc_out); end
    apply_edge(1'b0, 1'b0, 32'h0);
    checks++; if (id_inst !== 32'h2f000000 || id_pc !== 32'h40) begin errors++; $display("FAIL redir_stall_target got=%h/%h exp=2f000000/00000040", id_inst, id_pc); end
    $display("redirect+stall: id_pc=%h id_inst=%h", id_pc, id_inst);
    apply_edge(1'b0, 1'b1, 32'h100);
    apply_edge(1'b0, 1'b1, 32'h200);
    checks++; if (id_valid !== 1'b0 || pc_out !== 32'h200) begin errors++; $display("FAIL b2b_redirect got=%b/%h exp=0/00000200", id_valid, pc_out); end
    apply_edge(1'b0, 1'b0, 32'h0);
    checks++; if (id_pc !== 32'h200 || id_inst !== mem_word(32'h200) || id_valid !== 1'b1) begin errors++; $display("FAIL b2b_target got=%h/%h exp=00000200/%h", id_pc, id_inst, mem_word(32'h200)); end
    $display("back-to-back redirect: id_pc=%h", id_pc);
  endtask

  task automatic test_random();
    logic s, rv;
    logic [31:0] t;
    for (int i = 0; i < 200; i++) begin
      s  = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 15);
      t  = $urandom & 32'hFFFF_FFFC;
      apply_edge(s, rv, t);
      checks++;
      if (pc_out !== m_pc || id_inst !== m_inst || id_pc !== m_ipc || id_pc_next !== m_ipcn ||
          id_valid !== m_valid || misalign_err !== m_err) begin
        errors++;
        $display("FAIL random%0d got pc=%h inst=%h ipc=%h ipcn=%h v=%b e=%b exp pc=%h inst=%h ipc=%h ipcn=%h v=%b e=%b",
                 i, pc_out, id_inst, id_pc, id_pc_next, id_valid, misalign_err,
                 m_pc, m_inst, m_ipc, m_ipcn, m_valid, m_err);
      end
      $display("random %0d: stall=%b redir=%b pc_out=%h id_pc=%h valid=%b", i, s, rv, pc_out, id_pc, id_valid);
    end
  endtask

  task automatic test_misalign();
    apply_edge(1'b0, 1'b1, 32'h4a);
    checks++; if (pc_out !== 32'h48 || misalign_err !== 1'b1) begin errors++; $display("FAIL misalign got=%h/%b exp=00000048/1", pc_out, misalign_err); end
    for (int i = 0; i < 3; i++) begin
      apply_edge(1'b0, 1'b0, 32'h0);
      checks++; if (misalign_err !== 1'b1 || id_pc !== m_ipc) begin errors++; $display("FAIL misalign_sticky%0d got=%b/%h exp=1/%h", i, misalign_err, id_pc, m_ipc); end
    end
    $display("misalign: misalign_err=%b", misalign_err);
  endtask

  task automatic test_wrap_and_async_reset();
    apply_edge(1'b0, 1'b1, 32'hFFFF_FFFC);
    apply_edge(1'b0, 1'b0, 32'h0);
    checks++; if (pc_out !== 32'h0 || id_pc_next !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap got=%h/%h/%h exp=00000000/00000000/fffffffc", pc_out, id_pc_next, id_pc); end
    $display("wrap: pc_out=%h id_pc_next=%h", pc_out, id_pc_next);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    #2 reset = 1'b1;
    #1;
    checks++; if (pc_out !== 32'h40 || id_valid !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL async_reset got=%h/%b/%b exp=00000040/0/0", pc_out, id_valid, misalign_err); end
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h40 || id_inst !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_hold got=%h/%h/%h exp=00000040/00000000/00000000", pc_out, id_inst, id_pc); end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    model_reset();
    apply_edge(1'b0, 1'b0, 32'h0);
    checks++; if (id_inst !== 32'h2f000000 || id_valid !== 1'b1 || pc_out !== 32'h44) begin errors++; $display("FAIL post_reset got=%h/%b/%h exp=2f000000/1/00000044", id_inst, id_valid, pc_out); end
    $display("async reset: pc_out=%h id_inst=%h", pc_out, id_inst);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_random();
    test_misalign();
    test_wrap_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
